// File: rtl/apb_slave_regbank.sv
// APB completer holding a bank of 32-bit registers, the last of which is a
// read-only count of error-free transfers. Wait states and pslverr are generated locally.
module apb_slave_regbank #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 2,
    parameter bit          PRIV_REG0   = 1'b1
) (
    input  logic        s_axi_clk,
    input  logic        s_axi_areset,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_paddr,
    input  logic [31:0] apb_pwdata,
    input  logic [3:0]  apb_pstrb,
    input  logic [2:0]  apb_pprot,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic [31:0] xfer_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [7:0]  CNT_IDX   = 8'(NUM_REGS - 1);
    localparam logic [31:0] SPAN      = 32'(NUM_REGS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t                       state_q, state_d;
    logic [3:0]                   wcnt_q, wcnt_d;
    logic [7:0]                   idx_q, idx_d;
    logic                         write_q, write_d;
    logic                         err_q, err_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic [3:0]                   strb_q, strb_d;
    logic [31:0]                  count_q, count_d;
    logic [31:0]                  prdata_q, prdata_d;
    logic                         pready_q, pready_d;
    logic                         pslverr_q, pslverr_d;
    logic [NUM_REGS-2:0][31:0]    regs_q, regs_d;

    logic [31:0] off;
    logic [7:0]  dec_idx;
    logic        dec_hit, dec_err;
    logic [7:0]  cur_idx;
    logic        cur_write, cur_err;
    logic [31:0] rd_word;
    logic        enter_resp;
    logic        unused_prot;

    assign unused_prot = ^apb_pprot[2:1];

    always_comb begin
        off     = apb_paddr - BASE_ADDR;
        dec_idx = off[9:2];
        dec_hit = (off < SPAN) && (apb_paddr[1:0] == 2'b00);
        dec_err = !dec_hit
                  || (apb_pwrite && dec_idx == CNT_IDX)
                  || (apb_pwrite && PRIV_REG0 && dec_idx == 8'd0 && !apb_pprot[0]);
    end

    // With zero wait states the response is built straight from the setup-phase decode.
    always_comb begin
        cur_idx   = idx_q;
        cur_write = write_q;
        cur_err   = err_q;
        if (state_q == ST_IDLE) begin
            cur_idx   = dec_idx;
            cur_write = apb_pwrite;
            cur_err   = dec_err;
        end
        rd_word = count_q;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (cur_idx == 8'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        count_d    = count_q;
        regs_d     = regs_q;
        prdata_d   = '0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb_psel && !apb_penable) begin
                    idx_d   = dec_idx;
                    write_d = apb_pwrite;
                    err_d   = dec_err;
                    wdata_d = apb_pwdata;
                    strb_d  = apb_pstrb;
                    wcnt_d  = WAIT_INIT;
                    if (WAIT_STATES == 0) enter_resp = 1'b1;
                    else                  state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb_psel) begin
                    state_d = ST_IDLE;
                end else if (apb_penable) begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // The master samples pready at the end of this cycle; a dropped psel aborts.
                if (apb_psel && apb_penable && !err_q) begin
                    count_d = count_q + 32'd1;
                    if (write_q) begin
                        for (int i = 0; i < NUM_REGS - 1; i++) begin
                            if (idx_q == 8'(i)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            if (!cur_write && !cur_err) prdata_d = rd_word;
        end
    end

    always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            count_q   <= '0;
            regs_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            count_q   <= count_d;
            regs_q    <= regs_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign apb_prdata  = prdata_q;
    assign apb_pready  = pready_q;
    assign apb_pslverr = pslverr_q;
    assign xfer_count  = count_q;

endmodule
